add_sum_accum: RTL

//  Downstream consumer of the 8-bit adder stage. Takes the adder's registered
//  9-bit sum (c) and valid flag (v), and accumulates FRAME_LEN consecutive valid

---
 rtl/add_sum_accum_if.sv | 25 ++
 rtl/add_sum_accum.sv | 106 ++++++++++
 2 files changed

// File: rtl/add_sum_accum_if.sv
// Bus between the adder-sum accumulator and its neighbours. The master is the
// side that supplies sums and accepts frame totals; the slave is the
// accumulator itself.
interface add_sum_accum_if #(
    parameter int ACC_W = 12
);
    logic             in_v;
    logic [8:0]       in_c;
    logic             clr;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic             out_ovf;
    logic [7:0]       drop_cnt;

    modport master (
        output in_v, in_c, clr, out_ready,
        input  out_valid, out_sum, out_ovf, drop_cnt
    );

    modport slave (
        input  in_v, in_c, clr, out_ready,
        output out_valid, out_sum, out_ovf, drop_cnt
    );
endinterface

// File: rtl/add_sum_accum.sv
// Frame accumulator for the 8-bit adder stage. Sums FRAME_LEN valid 9-bit
// results into one total, offers it on a valid/ready port together with a
// wrap flag, and counts samples that arrive while a total is still waiting.
module add_sum_accum #(
    parameter int FRAME_LEN = 4,
    parameter int ACC_W     = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    add_sum_accum_if.slave     bus
);
    typedef enum logic [0:0] {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    // Count value at which the incoming sample closes the frame.
    localparam logic [7:0] LAST_CNT = 8'(FRAME_LEN - 1);

    state_t           state_r;
    logic [ACC_W-1:0] acc_r;
    logic [7:0]       cnt_r;
    logic             ovf_acc_r;
    logic             out_valid_r;
    logic [ACC_W-1:0] out_sum_r;
    logic             out_ovf_r;
    logic [7:0]       drop_cnt_r;

    // Extra top bit on both operands captures the carry out of ACC_W.
    logic [ACC_W:0]   in_ext_s;
    logic [ACC_W:0]   sum_s;

    // Zero-extend the incoming sum and add it to the running total.
    always_comb begin
        in_ext_s = {{(ACC_W-8){1'b0}}, bus.in_c};
        sum_s    = {1'b0, acc_r} + in_ext_s;
    end

    // Frame FSM: accumulate in ACC, present the total in HOLD until taken.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_ACC;
            acc_r       <= {ACC_W{1'b0}};
            cnt_r       <= 8'd0;
            ovf_acc_r   <= 1'b0;
            out_valid_r <= 1'b0;
            out_sum_r   <= {ACC_W{1'b0}};
            out_ovf_r   <= 1'b0;
            drop_cnt_r  <= 8'd0;
        end else if (bus.clr) begin
            // Abort: partial frame and any pending total are thrown away.
            state_r     <= ST_ACC;
            acc_r       <= {ACC_W{1'b0}};
            cnt_r       <= 8'd0;
            ovf_acc_r   <= 1'b0;
            out_valid_r <= 1'b0;
            drop_cnt_r  <= 8'd0;
        end else begin
            case (state_r)
                ST_ACC: begin
                    if (bus.in_v) begin
                        if (cnt_r == LAST_CNT) begin
                            out_sum_r   <= sum_s[ACC_W-1:0];
                            out_ovf_r   <= ovf_acc_r | sum_s[ACC_W];
                            out_valid_r <= 1'b1;
                            acc_r       <= {ACC_W{1'b0}};
                            cnt_r       <= 8'd0;
                            ovf_acc_r   <= 1'b0;
                            state_r     <= ST_HOLD;
                        end else begin
                            acc_r       <= sum_s[ACC_W-1:0];
                            ovf_acc_r   <= ovf_acc_r | sum_s[ACC_W];
                            cnt_r       <= cnt_r + 8'd1;
                        end
                    end
                end
                ST_HOLD: begin
                    // out_valid is always high here, so ready alone completes
                    // the handshake.
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        state_r     <= ST_ACC;
                        if (bus.in_v) begin
                            // Sample arriving with the handshake opens the
                            // next frame instead of being dropped.
                            acc_r     <= in_ext_s[ACC_W-1:0];
                            cnt_r     <= 8'd1;
                            ovf_acc_r <= 1'b0;
                        end
                    end else if (bus.in_v && (drop_cnt_r != 8'hFF)) begin
                        drop_cnt_r <= drop_cnt_r + 8'd1;
                    end
                end
                default: begin
                    state_r     <= ST_ACC;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.out_valid = out_valid_r;
    assign bus.out_sum   = out_sum_r;
    assign bus.out_ovf   = out_ovf_r;
    assign bus.drop_cnt  = drop_cnt_r;
endmodule
